// File: rtl/comb_monitor.sv
// Run-time checker for a 4-input combinational function with pass/fail counters, first-error capture
// and an optional mismatch log FIFO enabled by defining COMB_MONITOR_LOG_EN.
module comb_monitor #(
    parameter logic [15:0] TRUTH_TABLE = 16'hF888,
    parameter int          CNT_W       = 16,
    parameter int          LOG_DEPTH   = 4,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             smp_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             y,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [4:0]       first_err,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [4:0]       log_data,
    output logic             log_overflow
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_busy;
    logic             r_halted;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_err_flag;
    logic [4:0]       r_first_err;

    logic [3:0] w_idx;
    logic       w_exp;
    logic       w_match;
    logic       w_accept;
    logic       w_mismatch;

    assign w_idx      = {a, b, c, d};
    assign w_exp      = TRUTH_TABLE[w_idx];
    assign w_match    = (w_exp == y);
    // start has priority, so a sample arriving with start is never counted
    assign w_accept   = (r_state == ST_RUN) && smp_valid && !start;
    assign w_mismatch = w_accept && !w_match;

    // Control FSM; busy/halted are updated together with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end else if (STOP_ON_ERR && w_mismatch) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (stop) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Saturating counters and first-error capture
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_pass_cnt  <= {CNT_W{1'b0}};
            r_fail_cnt  <= {CNT_W{1'b0}};
            r_err_flag  <= 1'b0;
            r_first_err <= 5'd0;
        end else if (w_accept) begin
            if (w_match) begin
                if (r_pass_cnt != CNT_MAX) begin
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end
            end else begin
                if (r_fail_cnt != CNT_MAX) begin
                    r_fail_cnt <= r_fail_cnt + CNT_ONE;
                end
                if (!r_err_flag) begin
                    r_err_flag  <= 1'b1;
                    r_first_err <= {w_idx, y};
                end
            end
        end
    end

    assign busy      = r_busy;
    assign halted    = r_halted;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign err_flag  = r_err_flag;
    assign first_err = r_first_err;

`ifdef COMB_MONITOR_LOG_EN
    localparam int PTR_W = $clog2(LOG_DEPTH);

    logic [4:0]       r_mem [LOG_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == (PTR_W+1)'(1'b0));
    assign w_full  = (r_count == (PTR_W+1)'(LOG_DEPTH));
    assign w_pop   = !w_empty && log_ready;
    // a pop frees the slot in the same cycle, so a full log still accepts the push
    assign w_push  = w_mismatch && (!w_full || w_pop);
    assign w_drop  = w_mismatch && w_full && !w_pop;

    // Log storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_idx, y};
        end
    end

    // Log pointers, occupancy and overflow flag
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {(PTR_W+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1'b1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign log_valid    = !w_empty;
    assign log_data     = w_empty ? 5'd0 : r_mem[r_rd_ptr];
    assign log_overflow = r_overflow;
`else
    logic w_unused_log;
    assign w_unused_log = log_ready | (LOG_DEPTH < 2);
    assign log_valid    = 1'b0;
    assign log_data     = 5'd0;
    assign log_overflow = 1'b0;
`endif

endmodule
